pc_sequencer: RTL and testbench

Fetch sequencer that owns the processor's 16-bit program counter and drives instruction fetch. It issues one fetch at a time to instruction memory over a req/ack handshake and presents each fetched word to decode over a valid/ready handshake. When decode consumes a word, it selects the next PC: sequential, redirect (branch/jump), trap vector, or halt. It sits between instruction memory and the decode stage and replaces the free-running PC register.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_next_sel.sv | 49 ++++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared types and constants for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_TRAP     = 2'b01,
        CAUSE_MISALIGN = 2'b10
    } cause_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// Module   : pc_next_sel
// Brief    : Combinational next-PC / trap-cause priority select for a consume.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = 16'h0010,
    parameter logic [ADDR_W-1:0] PC_STEP     = 16'd2
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_trap,
    input  logic              i_halt,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_target,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_take_trap,
    output cause_t            o_cause,
    output logic              o_halt
);

    always_comb begin
        o_next_pc   = i_pc + PC_STEP;
        o_take_trap = 1'b0;
        o_cause     = CAUSE_NONE;
        o_halt      = 1'b0;
        if (i_trap) begin
            o_next_pc   = TRAP_VECTOR;
            o_take_trap = 1'b1;
            o_cause     = CAUSE_TRAP;
        end else if (i_halt) begin
            o_next_pc = i_pc;
            o_halt    = 1'b1;
        end else if (i_redirect_valid && i_redirect_target[0]) begin
            // Odd target cannot hold a 16-bit instruction: vector to trap.
            o_next_pc   = TRAP_VECTOR;
            o_take_trap = 1'b1;
            o_cause     = CAUSE_MISALIGN;
        end else if (i_redirect_valid) begin
            o_next_pc = i_redirect_target;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter owner; single-outstanding fetch with decode handoff.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 16'h0010,
    parameter logic [ADDR_W-1:0] PC_STEP      = 16'd2
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    input  logic [ADDR_W-1:0] fetch_data,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_out,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              trap,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] epc,
    output logic [1:0]        trap_cause,
    output logic              halted
);

    state_t            r_state_q,       w_state_d;
    logic              r_boot_q,        w_boot_d;
    logic [ADDR_W-1:0] r_pc_q,          w_pc_d;
    logic [ADDR_W-1:0] r_epc_q,         w_epc_d;
    cause_t            r_cause_q,       w_cause_d;
    logic [ADDR_W-1:0] r_instr_q,       w_instr_d;
    logic              r_fetch_req_q,   w_fetch_req_d;
    logic              r_instr_valid_q, w_instr_valid_d;
    logic              r_halted_q,      w_halted_d;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_take_trap;
    cause_t            w_sel_cause;
    logic              w_sel_halt;

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR),
        .PC_STEP     (PC_STEP)
    ) u_next_sel (
        .i_pc              (r_pc_q),
        .i_trap            (trap),
        .i_halt            (halt),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_next_pc         (w_next_pc),
        .o_take_trap       (w_take_trap),
        .o_cause           (w_sel_cause),
        .o_halt            (w_sel_halt)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_boot_d  = r_boot_q;
        w_pc_d    = r_pc_q;
        w_epc_d   = r_epc_q;
        w_cause_d = r_cause_q;
        w_instr_d = r_instr_q;
        case (r_state_q)
            // BOOT spends two edges so the first request follows the 2nd edge.
            BOOT: begin
                if (r_boot_q) w_state_d = FETCH;
                else          w_boot_d  = 1'b1;
            end
            FETCH: begin
                if (fetch_ack) begin
                    w_instr_d = fetch_data;
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (w_sel_halt) begin
                        w_state_d = HALT;
                    end else begin
                        w_state_d = FETCH;
                        w_pc_d    = w_next_pc;
                        if (w_take_trap) begin
                            w_epc_d   = r_pc_q;
                            w_cause_d = w_sel_cause;
                        end
                    end
                end
            end
            HALT:    w_state_d = HALT;
            default: w_state_d = BOOT;
        endcase
        // Outputs are registered copies of the state being entered.
        w_fetch_req_d   = (w_state_d == FETCH);
        w_instr_valid_d = (w_state_d == HOLD);
        w_halted_d      = (w_state_d == HALT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q       <= BOOT;
            r_boot_q        <= 1'b0;
            r_pc_q          <= RESET_VECTOR;
            r_epc_q         <= '0;
            r_cause_q       <= CAUSE_NONE;
            r_instr_q       <= '0;
            r_fetch_req_q   <= 1'b0;
            r_instr_valid_q <= 1'b0;
            r_halted_q      <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_boot_q        <= w_boot_d;
            r_pc_q          <= w_pc_d;
            r_epc_q         <= w_epc_d;
            r_cause_q       <= w_cause_d;
            r_instr_q       <= w_instr_d;
            r_fetch_req_q   <= w_fetch_req_d;
            r_instr_valid_q <= w_instr_valid_d;
            r_halted_q      <= w_halted_d;
        end
    end

    assign fetch_req   = r_fetch_req_q;
    assign fetch_addr  = r_pc_q;
    assign pc          = r_pc_q;
    assign instr_valid = r_instr_valid_q;
    assign instr_out   = r_instr_q;
    assign epc         = r_epc_q;
    assign trap_cause  = r_cause_q;
    assign halted      = r_halted_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed vector table plus randomized run against a fetch model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [15:0] fetch_data = '0;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = '0;
    logic        trap = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pc;
    logic [15:0] epc;
    logic [1:0]  trap_cause;
    logic        halted;

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ack       (fetch_ack),
        .fetch_data      (fetch_data),
        .instr_valid     (instr_valid),
        .instr_out       (instr_out),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .halt            (halt),
        .pc              (pc),
        .epc             (epc),
        .trap_cause      (trap_cause),
        .halted          (halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ack;
        logic [15:0] data;
        logic        ready;
        logic        rv;
        logic [15:0] tgt;
        logic        trp;
        logic        hlt;
        logic        req;
        logic [15:0] addr;
        logic        iv;
        logic [15:0] iout;
        logic [15:0] epc;
        logic [1:0]  cause;
        logic        halted;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic ack, input logic [15:0] data,
                               input logic ready, input logic rv, input logic [15:0] tgt,
                               input logic trp, input logic hlt,
                               input logic req, input logic [15:0] addr,
                               input logic iv, input logic [15:0] iout,
                               input logic [15:0] e, input logic [1:0] cause,
                               input logic hd);
        vec_t r;
        r.ack = ack; r.data = data; r.ready = ready; r.rv = rv; r.tgt = tgt;
        r.trp = trp; r.hlt = hlt; r.req = req; r.addr = addr; r.iv = iv;
        r.iout = iout; r.epc = e; r.cause = cause; r.halted = hd;
        return r;
    endfunction

    // {fetch_req, fetch_addr, pc, instr_valid, instr_out, epc, trap_cause, halted}
    function automatic logic [68:0] observed();
        return {fetch_req, fetch_addr, pc, instr_valid, instr_out, epc, trap_cause, halted};
    endfunction

    function automatic logic [68:0] bundle(input logic req, input logic [15:0] addr,
                                           input logic iv, input logic [15:0] iout,
                                           input logic [15:0] e, input logic [1:0] cause,
                                           input logic hd);
        return {req, addr, addr, iv, iout, e, cause, hd};
    endfunction

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req/addr/pc/iv/iout/epc/cause/halt=%h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [15:0] data, input logic ready,
                         input logic rv, input logic [15:0] tgt, input logic trp, input logic hlt);
        fetch_ack = ack; fetch_data = data; instr_ready = ready;
        redirect_valid = rv; redirect_target = tgt; trap = trp; halt = hlt;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: what the fetch unit has done so far, in plain terms.
    logic [15:0] m_pc, m_epc, m_instr;
    logic [1:0]  m_cause;
    logic        m_fetching, m_have, m_halted;
    int          m_boot;

    task automatic model_reset();
        m_pc = 16'h0000; m_epc = 16'h0000; m_instr = 16'h0000; m_cause = 2'b00;
        m_fetching = 1'b0; m_have = 1'b0; m_halted = 1'b0; m_boot = 0;
    endtask

    task automatic model_edge();
        if (m_halted) begin
        end else if (m_boot < 2) begin
            m_boot++;
            if (m_boot == 2) m_fetching = 1'b1;
        end else if (m_fetching) begin
            if (fetch_ack) begin
                m_instr = fetch_data; m_have = 1'b1; m_fetching = 1'b0;
            end
        end else if (m_have && instr_ready) begin
            m_have = 1'b0;
            if (trap) begin
                m_epc = m_pc; m_cause = 2'b01; m_pc = 16'h0010; m_fetching = 1'b1;
            end else if (halt) begin
                m_halted = 1'b1;
            end else if (redirect_valid && (redirect_target % 2 == 1)) begin
                m_epc = m_pc; m_cause = 2'b10; m_pc = 16'h0010; m_fetching = 1'b1;
            end else if (redirect_valid) begin
                m_pc = redirect_target; m_fetching = 1'b1;
            end else begin
                m_pc = 16'((32'(m_pc) + 2) % 65536); m_fetching = 1'b1;
            end
        end
    endtask

    function automatic logic [68:0] model_bundle();
        return bundle(m_fetching, m_pc, m_have, m_instr, m_epc, m_cause, m_halted);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("reset_values", observed(), bundle(0, 16'h0000, 0, 16'h0000, 16'h0000, 2'b00, 0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // ------------------------------ directed table
        tbl.push_back(v(0,16'h0000,1,0,16'h0000,0,0, 0,16'h0000,0,16'h0000,16'h0000,2'd0,0));
        tbl.push_back(v(1,16'h1111,1,0,16'h0000,1,0, 1,16'h0000,0,16'h0000,16'h0000,2'd0,0));
        tbl.push_back(v(1,16'hA000,0,0,16'h0000,0,0, 0,16'h0000,1,16'hA000,16'h0000,2'd0,0));
        tbl.push_back(v(1,16'h5555,1,0,16'h0000,0,0, 1,16'h0002,0,16'hA000,16'h0000,2'd0,0));
        tbl.push_back(v(1,16'hA002,0,0,16'h0000,0,0, 0,16'h0002,1,16'hA002,16'h0000,2'd0,0));
        tbl.push_back(v(0,16'h0000,1,0,16'h0000,0,0, 1,16'h0004,0,16'hA002,16'h0000,2'd0,0));
        tbl.push_back(v(1,16'hA004,0,0,16'h0000,0,0, 0,16'h0004,1,16'hA004,16'h0000,2'd0,0));
        tbl.push_back(v(0,16'h0000,1,1,16'h0100,0,0, 1,16'h0100,0,16'hA004,16'h0000,2'd0,0));
        tbl.push_back(v(1,16'hA100,0,0,16'h0000,0,0, 0,16'h0100,1,16'hA100,16'h0000,2'd0,0));
        tbl.push_back(v(0,16'h0000,1,1,16'h0006,0,0, 1,16'h0006,0,16'hA100,16'h0000,2'd0,0));
        tbl.push_back(v(1,16'hA006,0,0,16'h0000,0,0, 0,16'h0006,1,16'hA006,16'h0000,2'd0,0));
        tbl.push_back(v(0,16'h0000,1,1,16'h0200,1,0, 1,16'h0010,0,16'hA006,16'h0006,2'd1,0));
        tbl.push_back(v(1,16'hA010,0,0,16'h0000,0,0, 0,16'h0010,1,16'hA010,16'h0006,2'd1,0));
        tbl.push_back(v(0,16'h0000,1,1,16'h0008,0,0, 1,16'h0008,0,16'hA010,16'h0006,2'd1,0));
        tbl.push_back(v(1,16'hA008,0,0,16'h0000,0,0, 0,16'h0008,1,16'hA008,16'h0006,2'd1,0));
        tbl.push_back(v(0,16'h0000,1,1,16'h0101,0,0, 1,16'h0010,0,16'hA008,16'h0008,2'd2,0));
        tbl.push_back(v(1,16'hA010,0,0,16'h0000,0,0, 0,16'h0010,1,16'hA010,16'h0008,2'd2,0));
        tbl.push_back(v(0,16'h0000,1,1,16'hFFFE,0,0, 1,16'hFFFE,0,16'hA010,16'h0008,2'd2,0));
        tbl.push_back(v(1,16'hAFFE,0,0,16'h0000,0,0, 0,16'hFFFE,1,16'hAFFE,16'h0008,2'd2,0));
        tbl.push_back(v(0,16'h0000,1,0,16'h0000,0,0, 1,16'h0000,0,16'hAFFE,16'h0008,2'd2,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0,16'h0000,1,1,16'h0300,1,1, 1,16'h0000,0,16'hAFFE,16'h0008,2'd2,0));
        tbl.push_back(v(1,16'hA000,0,0,16'h0000,0,0, 0,16'h0000,1,16'hA000,16'h0008,2'd2,0));
        tbl.push_back(v(0,16'h0000,0,1,16'h0300,1,1, 0,16'h0000,1,16'hA000,16'h0008,2'd2,0));
        tbl.push_back(v(0,16'h0000,1,0,16'h0000,0,1, 0,16'h0000,0,16'hA000,16'h0008,2'd2,1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(v(1,16'hBEEF,1,1,16'h0400,1,0, 0,16'h0000,0,16'hA000,16'h0008,2'd2,1));

        drive(0, 16'h0, 0, 0, 16'h0, 0, 0);
        #2;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ack, tbl[i].data, tbl[i].ready, tbl[i].rv, tbl[i].tgt, tbl[i].trp, tbl[i].hlt);
            step();
            check($sformatf("table_row_%0d", i), observed(),
                  bundle(tbl[i].req, tbl[i].addr, tbl[i].iv, tbl[i].iout,
                         tbl[i].epc, tbl[i].cause, tbl[i].halted));
        end

        // ------------------------------ reset mid-FETCH with an ack in flight
        do_reset();
        drive(0, 16'h0, 0, 0, 16'h0, 0, 0);
        step(); step();
        check("mid_fetch_pre", observed(), bundle(1, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 0));
        drive(1, 16'hC0DE, 1, 0, 16'h0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_fetch_reset", observed(), bundle(0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 0));
        step();
        check("reset_held_ack", observed(), bundle(0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 0));
        reset_n = 1'b1;
        step();
        check("post_reset_boot", observed(), bundle(0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 0));
        step();
        check("post_reset_fetch", observed(), bundle(1, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 0));
        drive(1, 16'hC0DE, 0, 0, 16'h0, 0, 0);
        step();
        check("pre_hold_reset", observed(), bundle(0, 16'h0000, 1, 16'hC0DE, 16'h0000, 2'd0, 0));
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_hold_reset", observed(), bundle(0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 0));
        step();
        reset_n = 1'b1;
        model_reset();

        // ------------------------------ randomized run against the model
        for (int c = 0; c < 800; c++) begin
            if ((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 2) != 0, 16'($urandom),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                      {15'($urandom), 1'($urandom_range(0, 3) == 0)},
                      $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
                step();
                model_edge();
                check($sformatf("random_cycle_%0d", c), observed(), model_bundle());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
